// File: rtl/vector_adder_ctrl.sv
// Sequencer/arbiter for the A+B->C vector adder: post-reset sweep of C, then
// read / write-A / increment-A commands, each A change followed by a C recompute.
//
// state  | meaning
// SW_RD  | sweep: read A[idx], B[idx]
// SW_WR  | sweep: write C[idx] = A + B
// IDLE   | serve pending command or display C[addr]
// WR_A   | write A[paddr] = pdata
// INC_RD | read A[paddr]
// INC_WR | write A[paddr] = A + 1
// RC_RD  | recompute: read A[paddr], B[paddr]
// RC_WR  | recompute: write C[paddr]
module vector_adder_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] a_addr,
  output logic              a_we,
  output logic [DATA_W-1:0] a_wdata,
  input  logic [DATA_W-1:0] a_rdata,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] c_addr,
  output logic              c_we,
  output logic [DATA_W:0]   c_wdata,
  input  logic [DATA_W:0]   c_rdata,
  output logic [DATA_W:0]   disp_val,
  output logic              busy
);

  typedef enum logic [2:0] {
    SW_RD, SW_WR, IDLE, WR_A, INC_RD, INC_WR, RC_RD, RC_WR
  } state_t;

  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q;
  logic [1:0]          mode_q;
  logic                pending_q;
  logic                pop_inc_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pdata_q;
  logic [DATA_W:0]     disp_q;
  logic [ADDR_W-1:0]   a_addr_q, b_addr_q, c_addr_q;
  logic                disp_ld;
  logic                pend_clr;
  logic                start;
  logic [DATA_W:0]     sum;

  assign sum      = {1'b0, a_rdata} + {1'b0, b_rdata};
  assign start    = mode[1] && (mode_q == 2'b00);
  assign disp_val = disp_q;
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    a_addr   = a_addr_q;
    b_addr   = b_addr_q;
    c_addr   = c_addr_q;
    a_we     = 1'b0;
    a_wdata  = '0;
    c_we     = 1'b0;
    c_wdata  = '0;
    disp_ld  = 1'b0;
    pend_clr = 1'b0;
    case (state_q)
      SW_RD: begin
        a_addr  = idx_q;
        b_addr  = idx_q;
        state_d = SW_WR;
      end
      SW_WR: begin
        c_addr  = idx_q;
        c_we    = 1'b1;
        c_wdata = sum;
        state_d = (idx_q == IDX_LAST) ? IDLE : SW_RD;
      end
      IDLE: begin
        if (pending_q) begin
          pend_clr = 1'b1;
          state_d  = pop_inc_q ? INC_RD : WR_A;
        end else if (mode == 2'b01) begin
          c_addr  = addr;
          disp_ld = 1'b1;
        end
      end
      WR_A: begin
        a_addr  = paddr_q;
        a_we    = 1'b1;
        a_wdata = pdata_q;
        state_d = RC_RD;
      end
      INC_RD: begin
        a_addr  = paddr_q;
        state_d = INC_WR;
      end
      INC_WR: begin
        a_we    = 1'b1;
        a_wdata = a_rdata + 1'b1;
        state_d = RC_RD;
      end
      RC_RD: begin
        a_addr  = paddr_q;
        b_addr  = paddr_q;
        state_d = RC_WR;
      end
      RC_WR: begin
        c_addr  = paddr_q;
        c_we    = 1'b1;
        c_wdata = sum;
        state_d = IDLE;
      end
      default: state_d = SW_RD;
    endcase
    // an in-flight write must not land on the reset edge
    if (rst) begin
      a_we = 1'b0;
      c_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SW_RD;
      idx_q     <= '0;
      mode_q    <= 2'b00;
      pending_q <= 1'b0;
      disp_q    <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode;
      a_addr_q <= a_addr;
      b_addr_q <= b_addr;
      c_addr_q <= c_addr;
      if (state_q == SW_WR)
        idx_q <= idx_q + 1'b1;
      if (disp_ld)
        disp_q <= c_rdata;
      if (start && !pending_q) begin
        pending_q <= 1'b1;
        pop_inc_q <= mode[0];
        paddr_q   <= addr;
        pdata_q   <= data_in;
      end else if (pend_clr) begin
        pending_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vector_adder_ctrl.sv
// Self-checking bench for vector_adder_ctrl: bench-owned RAMs, a transaction-level
// model of expected RAM writes, directed checks and randomized commands.
module tb_vector_adder_ctrl;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;
  localparam int DATA_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        mode = 2'b00;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic [ADDR_W-1:0] a_addr, b_addr, c_addr;
  logic              a_we, c_we;
  logic [DATA_W-1:0] a_wdata, a_rdata, b_rdata;
  logic [DATA_W:0]   c_wdata, c_rdata, disp_val;
  logic              busy;

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];
  logic [DATA_W:0]   mem_c [DEPTH];
  logic              do_load = 1'b0;

  int ref_a [DEPTH];
  int ref_b [DEPTH];

  typedef struct {
    bit is_c;
    int adr;
    int dat;
  } wr_t;
  wr_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vector_adder_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .addr(addr), .data_in(data_in),
    .a_addr(a_addr), .a_we(a_we), .a_wdata(a_wdata), .a_rdata(a_rdata),
    .b_addr(b_addr), .b_rdata(b_rdata),
    .c_addr(c_addr), .c_we(c_we), .c_wdata(c_wdata), .c_rdata(c_rdata),
    .disp_val(disp_val), .busy(busy)
  );

  always @(posedge clk) begin
    if (do_load) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_a[i] <= DATA_W'(ref_a[i]);
        mem_b[i] <= DATA_W'(ref_b[i]);
        mem_c[i] <= '0;
      end
    end else begin
      if (a_we) mem_a[a_addr] <= a_wdata;
      if (c_we) mem_c[c_addr] <= c_wdata;
    end
    a_rdata <= mem_a[a_addr];
    b_rdata <= mem_b[b_addr];
    c_rdata <= mem_c[c_addr];
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_wr(input bit is_c, input int adr, input int dat);
    wr_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_write: ram %s addr %0d data %0d, none expected",
               is_c ? "C" : "A", adr, dat);
    end else begin
      e = exp_q.pop_front();
      if (e.is_c != is_c || e.adr != adr || e.dat != dat) begin
        n_err++;
        $display("FAIL write_seq: got ram %s addr %0d data %0d expected ram %s addr %0d data %0d",
                 is_c ? "C" : "A", adr, dat, e.is_c ? "C" : "A", e.adr, e.dat);
      end
    end
  endtask

  // every RAM write the DUT issues must be the next one the model predicts
  always @(negedge clk) begin
    if (a_we && c_we) begin
      n_err++;
      $display("FAIL we_exclusive: a_we=1 c_we=1 expected at most one");
    end
    if (rst && (a_we || c_we)) begin
      n_err++;
      $display("FAIL we_in_reset: a_we=%0d c_we=%0d expected 0", a_we, c_we);
    end
    if (a_we) check_wr(1'b0, int'(a_addr), int'(a_wdata));
    if (c_we) check_wr(1'b1, int'(c_addr), int'(c_wdata));
  end

  task automatic push_sweep();
    wr_t e;
    for (int i = 0; i < DEPTH; i++) begin
      e.is_c = 1'b1; e.adr = i; e.dat = ref_a[i] + ref_b[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic push_cmd(input int op, input int a, input int d);
    wr_t e;
    ref_a[a] = (op == 2) ? d : (ref_a[a] + 1) % 16;
    e.is_c = 1'b0; e.adr = a; e.dat = ref_a[a];
    exp_q.push_back(e);
    e.is_c = 1'b1; e.dat = ref_a[a] + ref_b[a];
    exp_q.push_back(e);
  endtask

  // called right after the reset edge; returns busy-high cycles after release
  task automatic sweep(input bit inject, output int cyc);
    @(negedge clk) rst = 1'b0;
    check("reset_disp_val", int'(disp_val), 0);
    check("reset_busy", int'(busy), 1);
    cyc = 0;
    while (busy && cyc < 5000) begin
      if (inject) begin
        case (cyc)
          100: begin mode = 2'b10; addr = 10'd3; data_in = 4'd9; push_cmd(2, 3, 9); end
          101: mode = 2'b00;
          104: begin mode = 2'b11; addr = 10'd7; end
          105: mode = 2'b00;
          default: ;
        endcase
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((busy || exp_q.size() != 0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (k >= 100) begin
      n_err++;
      $display("FAIL %s: still busy=%0d with %0d writes outstanding, expected idle",
               name, busy, exp_q.size());
    end
  endtask

  task automatic issue(input int op, input int a, input int d, input int exp_busy);
    int k = 0;
    int n = 0;
    @(negedge clk) mode = 2'b00;
    @(negedge clk);
    mode = 2'(op); addr = ADDR_W'(a); data_in = DATA_W'(d);
    push_cmd(op, a, d);
    @(negedge clk) mode = 2'b00;
    while (!busy && k < 10) begin @(negedge clk); k++; end
    while (busy && n < 20) begin @(negedge clk); n++; end
    check(op == 2 ? "write_busy_cycles" : "inc_busy_cycles", n, exp_busy);
  endtask

  task automatic read_disp(input int a, input int exp, input string name);
    @(negedge clk);
    mode = 2'b01; addr = ADDR_W'(a);
    repeat (2) @(negedge clk);
    check(name, int'(disp_val), exp);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int op, a, d, x;
    for (int i = 0; i < DEPTH; i++) begin
      ref_a[i] = i % 16;
      ref_b[i] = (i < 64 || i == DEPTH - 1) ? 2 : int'($urandom_range(0, 15));
    end
    do_load = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    do_load = 1'b0;
    exp_q.delete();
    push_sweep();
    @(posedge clk);
    sweep(1'b0, cyc);
    check("sweep_cycles", cyc, 2 * DEPTH);
    wait_idle("sweep_done");
    check("c0_after_sweep", int'(mem_c[0]), 2);
    check("c15_after_sweep", int'(mem_c[15]), 17);
    check("c1023_after_sweep", int'(mem_c[1023]), 17);

    read_disp(5, 7, "disp_addr5");
    @(negedge clk) addr = 10'd15;
    @(negedge clk) check("disp_lag_one_cycle", int'(disp_val), 7);
    @(negedge clk) check("disp_addr15", int'(disp_val), 17);

    issue(2, 8, 3, 3);
    check("a8_after_write", int'(mem_a[8]), 3);
    read_disp(8, 5, "disp_after_write");
    issue(3, 8, 0, 4);
    check("a8_after_inc", int'(mem_a[8]), 4);
    read_disp(8, 6, "disp_after_inc");
    issue(3, 15, 0, 4);
    check("a15_wrap", int'(mem_a[15]), 0);
    read_disp(15, 2, "disp_after_wrap");

    // command issued mid-sweep is held; a second one is dropped
    @(negedge clk);
    mode = 2'b00; rst = 1'b1;
    exp_q.delete();
    push_sweep();
    @(posedge clk);
    sweep(1'b1, cyc);
    check("sweep2_cycles", cyc, 2 * DEPTH);
    wait_idle("pending_done");
    read_disp(3, 11, "disp_pending_write");
    read_disp(7, 9, "disp_dropped_event");

    // reset lands in INC_WR with another command pending
    @(negedge clk) mode = 2'b00;
    @(negedge clk);
    mode = 2'b11; addr = 10'd20;
    @(posedge clk);
    @(negedge clk) mode = 2'b00;
    @(negedge clk);
    mode = 2'b10; addr = 10'd21; data_in = 4'd1;
    @(posedge clk);
    #1;
    rst = 1'b1; mode = 2'b00;
    exp_q.delete();
    push_sweep();
    @(posedge clk);
    sweep(1'b0, cyc);
    check("sweep3_cycles", cyc, 2 * DEPTH);
    repeat (10) @(negedge clk);
    check("pending_cleared_busy", int'(busy), 0);
    wait_idle("abort_done");
    check("a20_untouched", int'(mem_a[20]), 4);
    read_disp(20, 6, "disp_aborted_inc");
    read_disp(21, 7, "disp_dropped_pending");

    for (int it = 0; it < 24; it++) begin
      op = int'($urandom_range(2, 3));
      a  = int'($urandom_range(0, DEPTH - 1));
      d  = int'($urandom_range(0, 15));
      issue(op, a, d, (op == 2) ? 3 : 4);
      x = (it % 2 == 1) ? a : int'($urandom_range(0, DEPTH - 1));
      read_disp(x, ref_a[x] + ref_b[x], "disp_random");
    end
    wait_idle("final_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
